// File: rtl/window_watchdog_core.sv
// Windowed watchdog timing engine: closed/open service windows, fault counting,
// reset pulse and lockout. Optional window-tick prescaler enabled by WDT_PRESCALER_EN.
module window_watchdog_core #(
  parameter int TICK_DIV  = 16,
  parameter int RST_PULSE = 4
) (
  input  logic       CLK,
  input  logic       RST,
  input  logic [7:0] FWLEN,
  input  logic [7:0] SWLEN,
  input  logic [7:0] RST_LMT,
  input  logic       WDSRVC,
  input  logic       INIT,
  output logic       WDT_RST,
  output logic       FAULT,
  output logic [1:0] FLT_TYPE,
  output logic [7:0] FAULT_CNT,
  output logic [2:0] STATE,
  output logic [7:0] WIN_CNT
);

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_FIRST  = 3'd1,
    S_SECOND = 3'd2,
    S_PULSE  = 3'd3,
    S_LOCKED = 3'd4
  } state_e;

  localparam logic [1:0] FT_EARLY   = 2'b01;
  localparam logic [1:0] FT_TIMEOUT = 2'b10;

  localparam int            PW         = (RST_PULSE > 1) ? $clog2(RST_PULSE) : 1;
  localparam logic [PW-1:0] PULSE_LAST = PW'(RST_PULSE - 1);

  if (RST_PULSE < 1) begin : g_bad_rst_pulse
    $error("window_watchdog_core: RST_PULSE must be >= 1");
  end
  if (TICK_DIV < 2) begin : g_bad_tick_div
    $error("window_watchdog_core: TICK_DIV must be >= 2");
  end

  state_e        state_q, state_d;
  logic [7:0]    win_cnt_q, win_cnt_d;
  logic [7:0]    fault_cnt_q, fault_cnt_d;
  logic [1:0]    flt_type_q, flt_type_d;
  logic          fault_q, fault_d;
  logic          wdt_rst_q, wdt_rst_d;
  logic          wdsrvc_q, wdsrvc_d;
  logic [PW-1:0] pulse_cnt_q, pulse_cnt_d;

  logic       srv;
  logic       tick;
  logic       do_fault;
  logic [1:0] fault_kind;
  logic [7:0] win_next;
  logic [7:0] cnt_inc;

  assign wdsrvc_d = WDSRVC;
  assign srv      = WDSRVC & ~wdsrvc_q;
  assign win_next = win_cnt_q + 8'd1;
  assign cnt_inc  = (fault_cnt_q == 8'hFF) ? 8'hFF : fault_cnt_q + 8'd1;

`ifdef WDT_PRESCALER_EN
  localparam int            DW       = $clog2(TICK_DIV);
  localparam logic [DW-1:0] DIV_LAST = DW'(TICK_DIV - 1);

  logic [DW-1:0] presc_q, presc_d;
  logic          window_entry;

  assign tick = (presc_q == DIV_LAST);

  // Restarting the prescaler on every window entry makes a window exactly len * TICK_DIV cycles.
  always_comb begin
    window_entry = (state_d != state_q) && ((state_d == S_FIRST) || (state_d == S_SECOND));
    presc_d      = '0;
    if (!window_entry && ((state_q == S_FIRST) || (state_q == S_SECOND))) begin
      presc_d = tick ? '0 : presc_q + DW'(1);
    end
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      presc_q <= '0;
    end else begin
      presc_q <= presc_d;
    end
  end
`else
  assign tick = 1'b1;
`endif

  always_comb begin
    state_d     = state_q;
    win_cnt_d   = win_cnt_q;
    fault_cnt_d = fault_cnt_q;
    flt_type_d  = flt_type_q;
    fault_d     = 1'b0;
    wdt_rst_d   = wdt_rst_q;
    pulse_cnt_d = pulse_cnt_q;
    do_fault    = 1'b0;
    fault_kind  = 2'b00;

    case (state_q)
      S_IDLE: begin
        win_cnt_d = '0;
        wdt_rst_d = 1'b0;
        if (INIT) begin
          state_d = S_FIRST;
        end
      end

      S_FIRST: begin
        if (!INIT) begin
          state_d   = S_IDLE;
          win_cnt_d = '0;
        end else if (srv) begin
          do_fault   = 1'b1;
          fault_kind = FT_EARLY;
        end else if (FWLEN == 8'd0) begin
          state_d   = S_SECOND;
          win_cnt_d = '0;
        end else if (tick) begin
          if (win_next == FWLEN) begin
            state_d   = S_SECOND;
            win_cnt_d = '0;
          end else begin
            win_cnt_d = win_next;
          end
        end
      end

      S_SECOND: begin
        // Service is checked before expiry so a service on the last tick still counts.
        if (!INIT) begin
          state_d   = S_IDLE;
          win_cnt_d = '0;
        end else if (srv) begin
          state_d   = S_FIRST;
          win_cnt_d = '0;
        end else if (SWLEN == 8'd0) begin
          do_fault   = 1'b1;
          fault_kind = FT_TIMEOUT;
        end else if (tick) begin
          if (win_next == SWLEN) begin
            do_fault   = 1'b1;
            fault_kind = FT_TIMEOUT;
          end else begin
            win_cnt_d = win_next;
          end
        end
      end

      S_PULSE: begin
        if (pulse_cnt_q == PULSE_LAST) begin
          state_d   = INIT ? S_FIRST : S_IDLE;
          wdt_rst_d = 1'b0;
          win_cnt_d = '0;
        end else begin
          pulse_cnt_d = pulse_cnt_q + PW'(1);
        end
      end

      S_LOCKED: begin
        wdt_rst_d = 1'b1;
      end

      default: begin
        state_d   = S_IDLE;
        wdt_rst_d = 1'b0;
        win_cnt_d = '0;
      end
    endcase

    if (do_fault) begin
      fault_d     = 1'b1;
      flt_type_d  = fault_kind;
      fault_cnt_d = cnt_inc;
      win_cnt_d   = '0;
      pulse_cnt_d = '0;
      wdt_rst_d   = 1'b1;
      if ((RST_LMT != 8'd0) && (cnt_inc >= RST_LMT)) begin
        state_d = S_LOCKED;
      end else begin
        state_d = S_PULSE;
      end
    end
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q     <= S_IDLE;
      win_cnt_q   <= '0;
      fault_cnt_q <= '0;
      flt_type_q  <= 2'b00;
      fault_q     <= 1'b0;
      wdt_rst_q   <= 1'b0;
      wdsrvc_q    <= 1'b0;
      pulse_cnt_q <= '0;
    end else begin
      state_q     <= state_d;
      win_cnt_q   <= win_cnt_d;
      fault_cnt_q <= fault_cnt_d;
      flt_type_q  <= flt_type_d;
      fault_q     <= fault_d;
      wdt_rst_q   <= wdt_rst_d;
      wdsrvc_q    <= wdsrvc_d;
      pulse_cnt_q <= pulse_cnt_d;
    end
  end

  assign STATE     = state_q;
  assign WIN_CNT   = win_cnt_q;
  assign FAULT_CNT = fault_cnt_q;
  assign FLT_TYPE  = flt_type_q;
  assign FAULT     = fault_q;
  assign WDT_RST   = wdt_rst_q;

endmodule
